mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the instruction-fetch (IF) and
//  data (EXMEM load/store) requesters of the pipelined processor. Sequences each access
//  over a programmable number of wait states, returns read data with a one-cycle ack,
//  and drives per-requester stalls that the hazard controller ORs into PC/pipeline stalls.
//  Data accesses have priority; a starvation counter bounds how long fetch can lose.
// PARAMETERS
//  AW          16  address width (word address)
//  DW          16  data word width
//  WAIT         1  extra memory wait cycles per access (0..7); access = 1+WAIT cycles
//  STARVE_MAX   3  consecutive data grants while fetch waits before fetch is forced (>=1)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request (level, held until if_ack)
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetch read data, valid when if_ack=1
//  if_ack     out  1   one-cycle fetch completion pulse
//  d_req      in   1   data request (level, held until d_ack)
//  d_we       in   1   1=store, 0=load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_rdata    out  DW  load data, valid when d_ack=1
//  d_ack      out  1   one-cycle data completion pulse
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid by end of final access cycle
//  if_stall   out  1   if_req & ~if_ack
//  d_stall    out  1   d_req & ~d_ack
//  busy       out  1   1 while in ACCESS
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE, wait count=0, starve_cnt=0. Every
//    registered output is 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack,
//    if_rdata, d_rdata, busy. An in-flight access is aborted and gets no ack.
//  - States: IDLE, ACCESS. The owner register (IF/D) is valid in ACCESS.
//  - IDLE: at each rising edge, sample the eligible requests. A request is eligible
//    when its req=1 and its own ack=0 in that cycle. The ack cycle is therefore a
//    mandatory one-cycle turnaround: a req still held during its ack is not re-granted.
//  - Grant rule: if only one request is eligible, it wins. If both are eligible, D wins
//    unless starve_cnt==STARVE_MAX, in which case IF wins.
//  - starve_cnt: +1 (saturating at STARVE_MAX) when D wins while IF is eligible;
//    cleared when IF is granted.
//  - On grant: latch addr, wdata and we (we=0 for IF) into mem_*; set mem_en=1 and
//    busy=1; enter ACCESS with wait count=WAIT. Requester inputs are ignored while in
//    ACCESS.
//  - ACCESS: lasts 1+WAIT cycles. mem_en=1 throughout. mem_we=latched we throughout.
//    mem_addr and mem_wdata are stable throughout. At the edge ending the last cycle:
//    capture mem_rdata into the owner's rdata (loads/fetches only; a store leaves
//    d_rdata unchanged); pulse the owner's ack for exactly one cycle; clear mem_en,
//    mem_we and busy; return to IDLE. mem_addr and mem_wdata hold their last values.
//  - Latency: request sampled at edge k -> ACCESS spans cycles k..k+WAIT -> ack and
//    rdata valid in cycle k+WAIT+1 -> next grant no earlier than the edge ending that cycle.
//  - The ack cycle is an IDLE cycle, so the other requester can be granted at the edge
//    ending it. Back-to-back throughput is one access per 2+WAIT cycles.
//  - if_stall and d_stall are combinational from req and the registered ack.
//  - A request dropped before its grant is simply not serviced (no error).
// TESTING
//  1 reset=0 with both reqs high -> all outputs 0. Release; if_req, if_addr=0x0010,
//    mem[0x0010]=0x1234, WAIT=1 -> mem_en=1 for 2 cycles, if_ack in 3rd cycle,
//    if_rdata=0x1234, if_stall=1 until then.
//  2 if_req (0x0010) and d_req load (0x0200, mem=0x00AA) in same cycle -> D served
//    first, d_rdata=0x00AA; IF granted at the edge ending the d_ack cycle.
//  3 STARVE_MAX=3, if_req held, d_req re-presented every turnaround -> exactly 3 D grants,
//    then an IF grant; starve_cnt returns to 0; then D is served again.
//  4 store: d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_we=mem_en=1 for 1+WAIT cycles
//    with addr/data stable; d_ack pulse; d_rdata unchanged; a following load of 0x0040
//    returns 0xBEEF.
//  5 reset=0 during the 2nd ACCESS cycle -> mem_en/mem_we drop immediately, no ack;
//    after release, the held req is re-granted from IDLE and completes normally.
//  6 WAIT=0, if_req held high through its ack -> 1-cycle access, ack, 1 turnaround
//    cycle with no grant, then re-grant with the new if_addr.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port synchronous memory.
// Data accesses take priority; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int WAIT       = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_stall,
  output logic          d_stall,
  output logic          busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state;
  logic          owner_d;
  logic [2:0]    wcnt;
  logic [SW-1:0] starve_cnt;

  logic if_elig;
  logic d_elig;
  logic starved;
  logic grant_d;
  logic grant_if;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_MAX)) ? v : v + SW'(1);
  endfunction

  // A requester whose ack is high this cycle is in its turnaround and cannot win.
  assign if_elig  = if_req & ~if_ack;
  assign d_elig   = d_req & ~d_ack;
  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign grant_d  = d_elig & (~if_elig | ~starved);
  assign grant_if = if_elig & ~grant_d;

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      wcnt       <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            state    <= ACCESS;
            owner_d  <= grant_d;
            wcnt     <= 3'(WAIT);
            mem_en   <= 1'b1;
            busy     <= 1'b1;
            mem_we   <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
            if (grant_if) begin
              starve_cnt <= '0;
            end else if (if_elig) begin
              starve_cnt <= sat_inc(starve_cnt);
            end
          end
        end
        ACCESS: begin
          if (wcnt == 3'd0) begin
            // Final access cycle: memory data is valid now, so hand it to the owner.
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
